// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with bounded
// hold time and a one-cycle break-before-make gap between owners.
module mux41_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       sel_a_o,
    output logic       sel_b_o,
    output logic       valid_o,
    output logic [1:0] owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       owner_q;
    logic [1:0]       ptr_q;
    logic             valid_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    logic [1:0]       pick_s;
    logic             pick_found_s;
    logic             owner_req_s;
    logic             others_req_s;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Scan downward so the candidate closest to ptr is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = {1'b1, idx};
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    // Request decode: round-robin pick, owner request and competing requests.
    always_comb begin
        {pick_found_s, pick_s} = rr_pick(req_i, ptr_q);
        owner_req_s            = req_i[owner_q];
        others_req_s           = |(req_i & ~onehot(owner_q));
        if (hold_q == HOLD_LAST) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    hold_q <= '0;
                    if (pick_found_s) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= onehot(pick_s);
                        owner_q <= pick_s;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        valid_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Release on drop, or preempt once the hold budget is spent.
                    if (!owner_req_s || ((hold_q == HOLD_LAST) && others_req_s)) begin
                        state_q <= ST_GAP;
                        gnt_q   <= 4'b0000;
                        valid_q <= 1'b0;
                        ptr_q   <= owner_q + 2'd1;
                        hold_q  <= '0;
                    end else begin
                        state_q <= ST_GRANT;
                        hold_q  <= hold_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_a_o = owner_q[1];
    assign sel_b_o = owner_q[0];
    assign valid_o = valid_q;
    assign owner_o = owner_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter: directed scenarios plus random
// request traffic compared against a cycle-level behavioural model.
module tb_mux41_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 3;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel_a;
    logic       sel_b;
    logic       valid;
    logic [1:0] owner;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: whether someone holds the mux, who, for how many cycles,
    // and where the next round-robin scan starts.
    bit m_gr;
    int m_own;
    int m_run;
    int m_start;

    mux41_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .sel_a_o (sel_a),
        .sel_b_o (sel_b),
        .valid_o (valid),
        .owner_o (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gr    = 1'b0;
        m_own   = 0;
        m_run   = 0;
        m_start = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] one;
        bit         others;
        bit         found;
        int         j;
        one    = 4'b0001;
        others = (r & ~(one << m_own)) != 4'b0000;
        if (m_gr) begin
            if (!r[m_own] || (m_run >= MAX_HOLD && others)) begin
                m_gr    = 1'b0;
                m_start = (m_own + 1) % 4;
            end else begin
                m_run++;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                j = (m_start + k) % 4;
                if (!found && r[j]) begin
                    found = 1'b1;
                    m_gr  = 1'b1;
                    m_own = j;
                    m_run = 1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] one;
        logic [3:0] exp_gnt;
        one     = 4'b0001;
        exp_gnt = m_gr ? (one << m_own) : 4'b0000;
        chk({tag, ".gnt"},   gnt, exp_gnt);
        chk({tag, ".sel"},   {2'b00, sel_a, sel_b}, 4'(m_own));
        chk({tag, ".valid"}, {3'b000, valid}, {3'b000, m_gr});
        chk({tag, ".owner"}, {2'b00, owner}, 4'(m_own));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        #12;
        check_model("reset");
        rst = 1'b0;

        // 1: single requester granted one edge after request
        req = 4'b0001;
        step("t1");
        chk("t1.gnt_const", gnt, 4'b0001);
        chk("t1.valid_const", {3'b000, valid}, 4'b0001);
        for (int i = 0; i < 3; i++) step("t1.hold");

        // 2: all requesting, bounded hold with gaps and wrap
        req = 4'b1111;
        for (int i = 0; i < 22; i++) step("t2");

        // 3: lone requester keeps grant indefinitely
        req = 4'b0000;
        step("t3.drain");
        step("t3.drain");
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step("t3");
            chk("t3.gnt_const", gnt, 4'b0100);
            chk("t3.sel_const", {2'b00, sel_a, sel_b}, 4'b0010);
        end

        // 4: owner 0 drops on its 2nd grant cycle, 1 gap, then owner 1
        req = 4'b0000;
        step("t4.drain");
        step("t4.drain");
        req = 4'b0011;
        step("t4");
        chk("t4.gnt0", gnt, 4'b0001);
        step("t4");
        req = 4'b0010;
        step("t4");
        chk("t4.gap_gnt", gnt, 4'b0000);
        chk("t4.gap_sel", {2'b00, sel_a, sel_b}, 4'b0000);
        step("t4");
        chk("t4.gnt1", gnt, 4'b0010);
        chk("t4.sel1", {2'b00, sel_a, sel_b}, 4'b0001);

        // 5: owner 2 drops alone -> gap, idle with sel held; ptr then at 3
        req = 4'b0000;
        step("t5.drain");
        step("t5.drain");
        req = 4'b0100;
        step("t5");
        chk("t5.gnt2", gnt, 4'b0100);
        req = 4'b0000;
        step("t5");
        step("t5");
        chk("t5.idle_gnt", gnt, 4'b0000);
        chk("t5.idle_sel", {2'b00, sel_a, sel_b}, 4'b0010);
        req = 4'b0001;
        step("t5");
        chk("t5.gnt0", gnt, 4'b0001);

        // 6: asynchronous reset in the middle of owner 3's grant
        req = 4'b0000;
        step("t6.drain");
        step("t6.drain");
        req = 4'b1000;
        step("t6");
        step("t6");
        chk("t6.gnt3", gnt, 4'b1000);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6.rst_gnt", gnt, 4'b0000);
        chk("t6.rst_valid", {3'b000, valid}, 4'b0000);
        chk("t6.rst_sel", {2'b00, sel_a, sel_b}, 4'b0000);
        req = 4'b1010;
        #3 rst = 1'b0;
        step("t6.rel");
        chk("t6.rel_gnt", gnt, 4'b0010);

        // Random traffic: requests mostly held, occasionally redrawn
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
